mem_access: RTL and testbench

- Memory stage directly downstream of the execute stage.
- Consumes the load/store reservation-station cell (`op2_out`) and the effective address (`value2_out`) that execute produces.
- Performs the data-memory transaction over a req/gnt/rvalid bus and formats load data and store lanes.
- Hands a completed result cell, value and exception code to writeback/CDB through a valid/ready handshake. One transaction is in flight at a time.

---
 rtl/qu_common.sv | 59 +++++
 rtl/mem_access_if.sv | 51 +++++
 rtl/ldst_align.sv | 76 +++++++
 rtl/mem_access.sv | 189 ++++++++++++++++++
 tb/tb_mem_access.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/qu_common.sv
// ============================================================================
//  Module   : qu_common (package)
//  Purpose  : Shared types and constants for the memory-access stage:
//             reservation-station cell layout, FSM state encoding,
//             exception codes and RISC-V load/store funct3 encodings.
//  Ports    : n/a (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package qu_common;

  typedef enum logic [1:0] {
    OPT_ALU    = 2'd0,
    OPT_LOAD   = 2'd1,
    OPT_STORE  = 2'd2,
    OPT_BRANCH = 2'd3
  } optype_t;

  typedef struct packed {
    optype_t    optype;
    logic [2:0] funct3;
  } op_t;

  typedef struct packed {
    logic        busy;
    op_t         op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [3:0]  dest;
  } res_st_cell_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } mem_state_t;

  typedef enum logic [1:0] {
    EXC_NONE        = 2'b00,
    EXC_LD_MISALIGN = 2'b01,
    EXC_ST_MISALIGN = 2'b10,
    EXC_BUS_TIMEOUT = 2'b11
  } mem_exc_t;

  localparam logic [2:0] c_LB  = 3'b000;
  localparam logic [2:0] c_LH  = 3'b001;
  localparam logic [2:0] c_LW  = 3'b010;
  localparam logic [2:0] c_LBU = 3'b100;
  localparam logic [2:0] c_LHU = 3'b101;
  localparam logic [2:0] c_SB  = 3'b000;
  localparam logic [2:0] c_SH  = 3'b001;
  localparam logic [2:0] c_SW  = 3'b010;

endpackage

`default_nettype wire

// File: rtl/mem_access_if.sv
// ============================================================================
//  Module   : mem_access_if (interface)
//  Purpose  : Bundles the execute-side input handshake, the data-memory
//             req/gnt/rvalid bus and the writeback output handshake.
//  Modports : slave  - the memory stage (mem_access)
//             master - the surrounding environment (execute, memory, WB)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_if;
  import qu_common::*;

  logic         in_valid;
  logic         in_ready;
  res_st_cell_t in_cell;
  logic [31:0]  in_addr;
  logic         flush;

  logic         dmem_req;
  logic         dmem_we;
  logic [31:0]  dmem_addr;
  logic [31:0]  dmem_wdata;
  logic [3:0]   dmem_be;
  logic         dmem_gnt;
  logic         dmem_rvalid;
  logic [31:0]  dmem_rdata;

  logic         out_valid;
  logic         out_ready;
  res_st_cell_t out_cell;
  logic [31:0]  out_value;
  logic [1:0]   out_exc;

  modport slave (
    input  in_valid, in_cell, in_addr, flush,
    input  dmem_gnt, dmem_rvalid, dmem_rdata, out_ready,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output out_valid, out_cell, out_value, out_exc
  );

  modport master (
    output in_valid, in_cell, in_addr, flush,
    output dmem_gnt, dmem_rvalid, dmem_rdata, out_ready,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  out_valid, out_cell, out_value, out_exc
  );

endinterface

`default_nettype wire

// File: rtl/ldst_align.sv
// ============================================================================
//  Module   : ldst_align
//  Purpose  : Combinational lane formatting for loads and stores.
//  Ports    : i_addr_lo    - byte offset within the word
//             i_funct3     - load/store width/sign encoding
//             i_is_store   - 1 = store formatting, 0 = load formatting
//             i_store_data - raw store data (vk)
//             i_rdata      - raw load word from memory
//             o_be/o_wdata - byte enables / lane-replicated store data
//             o_load_value - extended load result
//             o_misaligned - access crosses its natural alignment
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldst_align
  import qu_common::*;
(
  input  wire logic [1:0]  i_addr_lo,
  input  wire logic [2:0]  i_funct3,
  input  wire logic        i_is_store,
  input  wire logic [31:0] i_store_data,
  input  wire logic [31:0] i_rdata,
  output logic      [3:0]  o_be,
  output logic      [31:0] o_wdata,
  output logic      [31:0] o_load_value,
  output logic             o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[8*i_addr_lo +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be         = 4'b1111;
    o_wdata      = 32'h0;
    o_load_value = i_rdata;
    o_misaligned = 1'b0;
    if (i_is_store) begin
      case (i_funct3)
        c_SB: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wdata = {4{i_store_data[7:0]}};
        end
        c_SH: begin
          o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wdata      = {2{i_store_data[15:0]}};
          o_misaligned = i_addr_lo[0];
        end
        default: begin
          o_wdata      = i_store_data;
          o_misaligned = |i_addr_lo;
        end
      endcase
    end else begin
      // funct3[2] selects zero extension for the byte/half variants.
      case (i_funct3)
        c_LB, c_LBU: begin
          o_load_value = i_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        end
        c_LH, c_LHU: begin
          o_load_value = i_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
          o_misaligned = i_addr_lo[0];
        end
        default: begin
          o_misaligned = |i_addr_lo;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
//  Module   : mem_access
//  Purpose  : Memory stage after execute. Runs one data-memory transaction
//             at a time over a req/gnt/rvalid bus and hands the result cell,
//             value and exception code to writeback.
//  Ports    : clk   - clock
//             rst_n - asynchronous active-low reset
//             bus   - mem_access_if.slave (input handshake, dmem bus,
//                     output handshake, flush)
//  Params   : XLEN (32 only), BUS_TIMEOUT (>=1 cycles of REQ without grant)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access
  import qu_common::*;
#(
  parameter int XLEN        = 32,
  parameter int BUS_TIMEOUT = 256
) (
  input wire logic     clk,
  input wire logic     rst_n,
  mem_access_if.slave  bus
);

  localparam int                 c_CNT_W    = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BUS_TIMEOUT - 1);

  mem_state_t         r_state;
  res_st_cell_t       r_cell;
  logic [1:0]         r_addr_lo;
  logic               r_req;
  logic               r_we;
  logic [XLEN-1:0]    r_daddr;
  logic [XLEN-1:0]    r_wdata;
  logic [3:0]         r_be;
  logic               r_out_valid;
  logic [XLEN-1:0]    r_out_value;
  mem_exc_t           r_out_exc;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_in_ready;
  logic               w_in_store;
  logic               w_cur_store;
  logic               w_idle;
  logic [1:0]         w_addr_lo;
  logic [2:0]         w_funct3;
  logic               w_is_store;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_load_value;
  logic               w_misaligned;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_in_ready  = w_idle && !bus.flush;
  assign w_in_store  = (bus.in_cell.op.optype == OPT_STORE);
  assign w_cur_store = (r_cell.op.optype == OPT_STORE);

  // One formatter serves both phases: the incoming op while idle (store
  // lanes, misalignment) and the captured op afterwards (load extension).
  assign w_addr_lo  = w_idle ? bus.in_addr[1:0]      : r_addr_lo;
  assign w_funct3   = w_idle ? bus.in_cell.op.funct3 : r_cell.op.funct3;
  assign w_is_store = w_idle ? w_in_store            : w_cur_store;

  ldst_align u_ldst_align (
    .i_addr_lo    (w_addr_lo),
    .i_funct3     (w_funct3),
    .i_is_store   (w_is_store),
    .i_store_data (bus.in_cell.vk),
    .i_rdata      (bus.dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_value (w_load_value),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cell      <= '0;
      r_addr_lo   <= 2'b00;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_daddr     <= '0;
      r_wdata     <= '0;
      r_be        <= 4'b0000;
      r_out_valid <= 1'b0;
      r_out_value <= '0;
      r_out_exc   <= EXC_NONE;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && w_in_ready) begin
            r_cell      <= bus.in_cell;
            r_addr_lo   <= bus.in_addr[1:0];
            r_out_value <= '0;
            if (w_misaligned) begin
              r_out_exc   <= w_in_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_out_exc <= EXC_NONE;
              r_req     <= 1'b1;
              r_we      <= w_in_store;
              r_daddr   <= {bus.in_addr[XLEN-1:2], 2'b00};
              r_be      <= w_be;
              r_wdata   <= w_wdata;
              r_state   <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          if (bus.dmem_gnt) begin
            // A granted store is committed even if flushed in the same cycle.
            r_req <= 1'b0;
            r_cnt <= '0;
            if (bus.flush) begin
              r_state <= r_we ? ST_IDLE : ST_DRAIN;
            end else if (r_we) begin
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
            end
          end else if (bus.flush) begin
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (r_cnt == c_CNT_LAST) begin
            r_req       <= 1'b0;
            r_cnt       <= '0;
            r_out_exc   <= EXC_BUS_TIMEOUT;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_WAIT: begin
          if (bus.dmem_rvalid) begin
            if (bus.flush) begin
              r_state <= ST_IDLE;
            end else begin
              r_out_value <= w_load_value;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end else if (bus.flush) begin
            r_state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (bus.dmem_rvalid) begin
            r_state <= ST_IDLE;
          end
        end

        ST_DONE: begin
          if (bus.flush || bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.dmem_req   = r_req;
  assign bus.dmem_we    = r_we;
  assign bus.dmem_addr  = r_daddr;
  assign bus.dmem_wdata = r_wdata;
  assign bus.dmem_be    = r_be;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_cell   = r_cell;
  assign bus.out_value  = r_out_value;
  assign bus.out_exc    = r_out_exc;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
//  Module   : tb_mem_access
//  Purpose  : Directed self-checking bench for mem_access (BUS_TIMEOUT = 4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;
  import qu_common::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_if bus ();

  mem_access #(
    .XLEN        (32),
    .BUS_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic res_st_cell_t mk(optype_t t, logic [2:0] f3, logic [31:0] vk, logic [3:0] dest);
    res_st_cell_t c;
    c           = '0;
    c.busy      = 1'b1;
    c.op.optype = t;
    c.op.funct3 = f3;
    c.vk        = vk;
    c.dest      = dest;
    return c;
  endfunction

  // Present one op for a single cycle; on return we are in the cycle after acceptance.
  task automatic present(input res_st_cell_t c, input logic [31:0] a);
    bus.in_valid = 1'b1;
    bus.in_cell  = c;
    bus.in_addr  = a;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic retire;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int n_req;
    bus.in_valid    = 1'b0;
    bus.in_cell     = '0;
    bus.in_addr     = 32'h0;
    bus.flush       = 1'b0;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'h0;
    bus.out_ready   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",       32'(bus.dmem_req),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_be",        32'(bus.dmem_be),   32'd0);
    chk("rst_value",     bus.out_value,      32'd0);
    chk("rst_exc",       32'(bus.out_exc),   32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // LB at 0x1003: gnt cycle 1, rvalid cycle 2, out_valid cycle 3
    present(mk(OPT_LOAD, 3'b000, 32'h0, 4'd5), 32'h0000_1003);
    chk("lb_req",   32'(bus.dmem_req),  32'd1);
    chk("lb_addr",  bus.dmem_addr,      32'h0000_1000);
    chk("lb_be",    32'(bus.dmem_be),   32'hF);
    chk("lb_we",    32'(bus.dmem_we),   32'd0);
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    chk("lb_req_drop",  32'(bus.dmem_req),  32'd0);
    chk("lb_no_valid2", 32'(bus.out_valid), 32'd0);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h80FF_1234;
    tick();
    bus.dmem_rvalid = 1'b0;
    chk("lb_valid3", 32'(bus.out_valid), 32'd1);
    chk("lb_value",  bus.out_value,      32'hFFFF_FF80);
    chk("lb_exc",    32'(bus.out_exc),   32'd0);
    chk("lb_dest",   32'(bus.out_cell.dest), 32'd5);
    chk("lb_busy_ready", 32'(bus.in_ready), 32'd0);
    retire();
    chk("lb_retired",  32'(bus.out_valid), 32'd0);
    chk("lb_ready_back", 32'(bus.in_ready), 32'd1);

    // SH at 0x2002, grant delayed 3 cycles (lands on the last allowed REQ cycle)
    present(mk(OPT_STORE, 3'b001, 32'h1234_ABCD, 4'd6), 32'h0000_2002);
    for (int i = 0; i < 3; i++) begin
      chk("sh_req_held", 32'(bus.dmem_req),  32'd1);
      chk("sh_be",       32'(bus.dmem_be),   32'hC);
      chk("sh_wdata",    bus.dmem_wdata,     32'hABCD_ABCD);
      chk("sh_we",       32'(bus.dmem_we),   32'd1);
      tick();
    end
    chk("sh_addr", bus.dmem_addr, 32'h0000_2000);
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    chk("sh_valid", 32'(bus.out_valid), 32'd1);
    chk("sh_value", bus.out_value,      32'd0);
    chk("sh_exc",   32'(bus.out_exc),   32'd0);
    chk("sh_req_off", 32'(bus.dmem_req), 32'd0);
    retire();

    // Misaligned LW / SW: no bus request, result next cycle
    present(mk(OPT_LOAD, 3'b010, 32'h0, 4'd1), 32'h0000_3001);
    chk("lw_mis_req",   32'(bus.dmem_req),  32'd0);
    chk("lw_mis_valid", 32'(bus.out_valid), 32'd1);
    chk("lw_mis_exc",   32'(bus.out_exc),   32'd1);
    retire();
    present(mk(OPT_STORE, 3'b010, 32'h5555_5555, 4'd2), 32'h0000_3002);
    chk("sw_mis_req",   32'(bus.dmem_req),  32'd0);
    chk("sw_mis_valid", 32'(bus.out_valid), 32'd1);
    chk("sw_mis_exc",   32'(bus.out_exc),   32'd2);
    retire();

    // LHU at 0x4002 with writeback back-pressure
    present(mk(OPT_LOAD, 3'b101, 32'h0, 4'd7), 32'h0000_4002);
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hBEEF_0000;
    tick();
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      chk("lhu_valid_hold", 32'(bus.out_valid), 32'd1);
      chk("lhu_value_hold", bus.out_value,      32'h0000_BEEF);
      chk("lhu_in_ready",   32'(bus.in_ready),  32'd0);
      tick();
    end
    retire();
    chk("lhu_ready_back", 32'(bus.in_ready), 32'd1);

    // Bus timeout: request stays up exactly BUS_TIMEOUT cycles
    present(mk(OPT_LOAD, 3'b010, 32'h0, 4'd3), 32'h0000_5000);
    n_req = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.dmem_req !== 1'b1) break;
      n_req++;
      tick();
    end
    chk("to_req_cycles", 32'(n_req),          32'd4);
    chk("to_valid",      32'(bus.out_valid),  32'd1);
    chk("to_exc",        32'(bus.out_exc),    32'd3);
    retire();

    // Load flushed in WAIT, response arrives two cycles later
    present(mk(OPT_LOAD, 3'b010, 32'h0, 4'd4), 32'h0000_6000);
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    bus.flush    = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_state_drain", 32'(dut.r_state),   32'(ST_DRAIN));
    chk("fl_in_ready0",   32'(bus.in_ready),  32'd0);
    tick();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("fl_in_ready1",   32'(bus.in_ready),  32'd0);
    tick();
    bus.dmem_rvalid = 1'b0;
    chk("fl_no_valid",    32'(bus.out_valid), 32'd0);
    chk("fl_ready_back",  32'(bus.in_ready),  32'd1);

    // Flush together with in_valid in IDLE: nothing accepted
    bus.flush = 1'b1;
    #1;
    chk("fli_in_ready", 32'(bus.in_ready), 32'd0);
    present(mk(OPT_LOAD, 3'b010, 32'h0, 4'd9), 32'h0000_7000);
    bus.flush = 1'b0;
    #1;
    chk("fli_no_req",   32'(bus.dmem_req),  32'd0);
    chk("fli_no_valid", 32'(bus.out_valid), 32'd0);
    chk("fli_ready",    32'(bus.in_ready),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
